pulsegen_multi: RTL and testbench
=================================

# pulsegen_multi

Parametrised multi-channel successor to the single-channel pulse generator. Each of `NUM_CH` independent channels emits a programmable train of pulses (high width, period, pulse count or continuous), optionally gated by an external IP-sync input. Sits behind the AXI-Lite register block in the sensor PL; the register block drives the flat configuration and strobe ports directly.

## Interface
- `NUM_CH`, 4: number of independent channels (1..16).
- `CNT_W`, 32: width of the period, high-width and pulse-count fields.
- `S_AXI_ACLK`  in  1: single clock; all logic on the rising edge.
- `S_AXI_ARESETN`  in  1: reset, asynchronous assert, active-low.
- `period_i`  in  NUM_CH*CNT_W: per-channel period in cycles; channel c is bits [c*CNT_W +: CNT_W].
- `width_i`  in  NUM_CH*CNT_W: per-channel high-phase length in cycles.
- `count_i`  in  NUM_CH*CNT_W: pulses per run; 0 = continuous.
- `sync_en_i`  in  NUM_CH: 1 = wait for `sync_i` after start.
- `start_i`  in  NUM_CH: one-cycle start strobe per channel.
- `stop_i`  in  NUM_CH: one-cycle abort strobe per channel.
- `sync_i`  in  1: shared IP-sync level, synchronous to `S_AXI_ACLK`.
- `pulse_o`  out  NUM_CH: registered pulse outputs.
- `busy_o`  out  NUM_CH: channel not IDLE.
- `done_o`  out  NUM_CH: one-cycle strobe at normal run completion.

## Operation
- Per-channel FSM: IDLE, ARMED, HIGH, LOW. Channels share nothing except `sync_i`.
- IDLE: on `start_i[c]`, latch period/width/count/sync_en into shadow registers. Go to ARMED if sync_en, else HIGH. Config-port changes after the start have no effect until the next start.
- ARMED: on `sync_i`=1, go to HIGH. Level-sensitive, not edge.
- HIGH: `pulse_o`=1 for `width` cycles, then LOW.
- LOW: `pulse_o`=0 for `period - width` cycles. Then either:
  - if pulses emitted == count (count≠0), go to IDLE and strobe `done_o`;
  - else go to HIGH.
- Arithmetic:
  - Low length is `period - width` computed unsigned in CNT_W bits. If `width >= period`, low length is 1.
  - `width == 0`: start goes straight to IDLE with a `done_o` strobe and no pulse (also when sync_en; no sync wait).
  - Pulse counter is CNT_W bits. Continuous mode never compares it and lets it wrap freely.
- `stop_i[c]` in any state: go to IDLE next cycle, `pulse_o` low, no `done_o`.
- Simultaneous events:
  - `stop_i` + `start_i` in the same cycle: stop wins; the start is dropped.
  - `start_i` while busy: ignored.
- `sync_i` has no effect outside ARMED.
- Reset (any time, including mid-pulse): all FSMs to IDLE; `pulse_o`, `busy_o`, `done_o`, counters and shadow registers all 0.

## Timing
- Start sampled at edge N (sync_en=0): `pulse_o`=1 and `busy_o`=1 from edge N+1.
- ARMED exit: `sync_i` sampled high at edge M gives `pulse_o`=1 from M+1. `busy_o`=1 from the edge after start.
- Pulse shape: exactly `width` cycles high and `max(period-width,1)` cycles low, so rising edges are `period` cycles apart when width<period.
- Completion: `done_o` is high for the single cycle immediately after the last LOW cycle. `busy_o` falls on that same edge. A new start is accepted in that `done_o` cycle.
- Stop at edge S: `pulse_o`=0 and `busy_o`=0 from S+1.
- Reset assertion clears outputs asynchronously. The first start is accepted on the first rising edge after deassertion.

## Test plan
- Ch0: period=10, width=3, count=4, no sync. Required: 4 pulses 3 cycles high with rising edges 10 cycles apart, pulse at start+1, `done_o` one cycle at start+41, `busy_o` low from start+41.
- Ch1: sync_en=1, period=8, width=2, count=2, `sync_i` held low 20 cycles then high. Required: no pulse for 20 cycles, first pulse the cycle after sync rises, then 2 pulses and `done_o`.
- Ch2: continuous (count=0), period=5, width=5. Required: 5 high / 1 low repeating. `stop_i` mid-HIGH gives `pulse_o` low next cycle and no `done_o`.
- All channels started on the same cycle with distinct periods 4/6/7/9. Required: independent trains. `start_i` on busy ch3 ignored; `start_i`+`stop_i` together on ch0 leaves ch0 IDLE.
- width=0: `done_o` the cycle after start with no pulse. Separately, config ports changed mid-run: train unaffected.
- Assert `S_AXI_ARESETN` low mid-pulse. Required: all outputs 0 immediately; after release, a fresh start with period=6, width=1, count=1 produces 1 pulse and `done_o`.

Source files
------------

// File: rtl/pulsegen_multi.sv
// pulsegen_multi: NUM_CH independent programmable pulse-train generators.
// Each channel latches period/width/count at start, optionally waits for
// the shared sync level, then emits width-high / max(period-width,1)-low
// pulses either count times (done_o strobe at the end) or continuously.
//
// Ports:
//   S_AXI_ACLK, S_AXI_ARESETN   clock, async active-low reset
//   period_i, width_i, count_i  flat per-channel config, CNT_W bits each
//   sync_en_i                   per-channel: wait for sync_i after start
//   start_i, stop_i             per-channel one-cycle strobes
//   sync_i                      shared sync level
//   pulse_o, busy_o, done_o     per-channel outputs
module pulsegen_multi #(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = 32
) (
    input  logic                    S_AXI_ACLK,
    input  logic                    S_AXI_ARESETN,
    input  logic [NUM_CH*CNT_W-1:0] period_i,
    input  logic [NUM_CH*CNT_W-1:0] width_i,
    input  logic [NUM_CH*CNT_W-1:0] count_i,
    input  logic [NUM_CH-1:0]       sync_en_i,
    input  logic [NUM_CH-1:0]       start_i,
    input  logic [NUM_CH-1:0]       stop_i,
    input  logic                    sync_i,
    output logic [NUM_CH-1:0]       pulse_o,
    output logic [NUM_CH-1:0]       busy_o,
    output logic [NUM_CH-1:0]       done_o
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ARMED = 2'd1;
    localparam logic [1:0] S_HIGH  = 2'd2;
    localparam logic [1:0] S_LOW   = 2'd3;

    localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] ZERO = '0;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        logic [1:0]       st_q, st_d;
        logic [CNT_W-1:0] per_q, per_d;
        logic [CNT_W-1:0] wid_q, wid_d;
        logic [CNT_W-1:0] cnt_q, cnt_d;
        logic [CNT_W-1:0] rem_q, rem_d;
        logic [CNT_W-1:0] np_q, np_d;
        logic             pulse_q, pulse_d;
        logic             done_q, done_d;
        logic [CNT_W-1:0] low_len;
        logic [CNT_W-1:0] per_in, wid_in, cnt_in;

        assign per_in = period_i[c*CNT_W +: CNT_W];
        assign wid_in = width_i[c*CNT_W +: CNT_W];
        assign cnt_in = count_i[c*CNT_W +: CNT_W];

        // Degenerate width >= period still gets a one-cycle low gap.
        assign low_len = (wid_q >= per_q) ? ONE : per_q - wid_q;

        always_comb begin
            st_d    = st_q;
            per_d   = per_q;
            wid_d   = wid_q;
            cnt_d   = cnt_q;
            rem_d   = rem_q;
            np_d    = np_q;
            pulse_d = pulse_q;
            done_d  = 1'b0;
            if (stop_i[c]) begin
                st_d    = S_IDLE;
                pulse_d = 1'b0;
            end else begin
                unique case (st_q)
                    S_IDLE: begin
                        if (start_i[c]) begin
                            per_d = per_in;
                            wid_d = wid_in;
                            cnt_d = cnt_in;
                            np_d  = ZERO;
                            if (wid_in == ZERO) begin
                                done_d = 1'b1;
                            end else if (sync_en_i[c]) begin
                                st_d = S_ARMED;
                            end else begin
                                st_d    = S_HIGH;
                                rem_d   = wid_in;
                                pulse_d = 1'b1;
                            end
                        end
                    end
                    S_ARMED: begin
                        if (sync_i) begin
                            st_d    = S_HIGH;
                            rem_d   = wid_q;
                            pulse_d = 1'b1;
                        end
                    end
                    S_HIGH: begin
                        if (rem_q == ONE) begin
                            st_d    = S_LOW;
                            rem_d   = low_len;
                            pulse_d = 1'b0;
                            // Counts pulses completed; wraps in continuous mode.
                            np_d    = np_q + ONE;
                        end else begin
                            rem_d = rem_q - ONE;
                        end
                    end
                    S_LOW: begin
                        if (rem_q == ONE) begin
                            if (cnt_q != ZERO && np_q == cnt_q) begin
                                st_d   = S_IDLE;
                                done_d = 1'b1;
                            end else begin
                                st_d    = S_HIGH;
                                rem_d   = wid_q;
                                pulse_d = 1'b1;
                            end
                        end else begin
                            rem_d = rem_q - ONE;
                        end
                    end
                    default: begin
                        st_d    = S_IDLE;
                        pulse_d = 1'b0;
                    end
                endcase
            end
        end

        always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
            if (!S_AXI_ARESETN) begin
                st_q    <= S_IDLE;
                per_q   <= '0;
                wid_q   <= '0;
                cnt_q   <= '0;
                rem_q   <= '0;
                np_q    <= '0;
                pulse_q <= 1'b0;
                done_q  <= 1'b0;
            end else begin
                st_q    <= st_d;
                per_q   <= per_d;
                wid_q   <= wid_d;
                cnt_q   <= cnt_d;
                rem_q   <= rem_d;
                np_q    <= np_d;
                pulse_q <= pulse_d;
                done_q  <= done_d;
            end
        end

        assign pulse_o[c] = pulse_q;
        assign busy_o[c]  = (st_q != S_IDLE);
        assign done_o[c]  = done_q;
    end

endmodule

// File: tb/tb_pulsegen_multi.sv
// tb_pulsegen_multi: scoreboard bench for pulsegen_multi.
// Expected outputs come from a closed-form per-channel train timeline.
module tb_pulsegen_multi;

    localparam int NCH = 4;
    localparam int CW  = 32;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic [NCH*CW-1:0] period_i = '0;
    logic [NCH*CW-1:0] width_i  = '0;
    logic [NCH*CW-1:0] count_i  = '0;
    logic [NCH-1:0]    sync_en_i = '0;
    logic [NCH-1:0]    start_i   = '0;
    logic [NCH-1:0]    stop_i    = '0;
    logic              sync_i    = 1'b0;
    logic [NCH-1:0]    pulse_o, busy_o, done_o;

    always #5 clk = ~clk;

    pulsegen_multi #(.NUM_CH(NCH), .CNT_W(CW)) dut (
        .S_AXI_ACLK   (clk),
        .S_AXI_ARESETN(rst_n),
        .period_i     (period_i),
        .width_i      (width_i),
        .count_i      (count_i),
        .sync_en_i    (sync_en_i),
        .start_i      (start_i),
        .stop_i       (stop_i),
        .sync_i       (sync_i),
        .pulse_o      (pulse_o),
        .busy_o       (busy_o),
        .done_o       (done_o)
    );

    typedef struct {
        bit act;
        int s;
        int h0;
        int w;
        int p;
        int n;
        int stop_e;
        bit wait_s;
    } plan_t;

    plan_t plan [NCH];
    logic [3*NCH-1:0] sb_q [$];
    int cyc     = 0;
    int vectors = 0;
    int errs    = 0;

    // {done, busy, pulse} for channel ch after clock edge c.
    function automatic logic [2:0] exp_at(input int ch, input int c);
        int lo, per, rel;
        if (!plan[ch].act || c <= plan[ch].s) return 3'b000;
        if (plan[ch].stop_e >= 0 && c > plan[ch].stop_e) return 3'b000;
        if (plan[ch].w == 0) return (c == plan[ch].s + 1) ? 3'b100 : 3'b000;
        if (c < plan[ch].h0) return 3'b010;
        lo  = (plan[ch].w >= plan[ch].p) ? 1 : plan[ch].p - plan[ch].w;
        per = plan[ch].w + lo;
        rel = c - plan[ch].h0;
        if (plan[ch].n != 0 && rel >= plan[ch].n * per)
            return (rel == plan[ch].n * per) ? 3'b100 : 3'b000;
        return {1'b0, 1'b1, ((rel % per) < plan[ch].w)};
    endfunction

    task automatic clear_plans();
        for (int c = 0; c < NCH; c++) begin
            plan[c].act    = 1'b0;
            plan[c].stop_e = -1;
            plan[c].wait_s = 1'b0;
        end
    endtask

    task automatic arm(input int ch, input int p, input int w,
                       input int n, input bit se);
        period_i[ch*CW +: CW] = p;
        width_i[ch*CW +: CW]  = w;
        count_i[ch*CW +: CW]  = n;
        sync_en_i[ch]         = se;
        start_i[ch]           = 1'b1;
    endtask

    // Update the model from this cycle's inputs, push the expectation for
    // the coming edge, clock, then pop and compare.
    task automatic step(input string tag);
        logic [3*NCH-1:0] e;
        logic [2:0] cur, got, want;
        for (int c = 0; c < NCH; c++) begin
            cur = exp_at(c, cyc);
            if (stop_i[c]) begin
                if (plan[c].act && plan[c].stop_e < 0) plan[c].stop_e = cyc;
            end else if (start_i[c] && !cur[1]) begin
                plan[c].act    = 1'b1;
                plan[c].s      = cyc;
                plan[c].p      = int'(period_i[c*CW +: CW]);
                plan[c].w      = int'(width_i[c*CW +: CW]);
                plan[c].n      = int'(count_i[c*CW +: CW]);
                plan[c].stop_e = -1;
                plan[c].wait_s = sync_en_i[c] && (plan[c].w != 0);
                plan[c].h0     = plan[c].wait_s ? 32'h7fff_ffff : cyc + 1;
            end
            if (plan[c].wait_s && sync_i && cyc > plan[c].s
                && plan[c].stop_e < 0) begin
                plan[c].h0     = cyc + 1;
                plan[c].wait_s = 1'b0;
            end
        end
        for (int c = 0; c < NCH; c++) e[3*c +: 3] = exp_at(c, cyc + 1);
        sb_q.push_back(e);
        @(posedge clk);
        cyc++;
        #1;
        start_i = '0;
        stop_i  = '0;
        e = sb_q.pop_front();
        for (int c = 0; c < NCH; c++) begin
            got  = {done_o[c], busy_o[c], pulse_o[c]};
            want = e[3*c +: 3];
            vectors++;
            if (got !== want) begin
                errs++;
                $display("FAIL %s ch%0d cyc%0d: got d/b/p=%b want %b",
                         tag, c, cyc, got, want);
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        clear_plans();
        repeat (3) @(posedge clk);
        #1;
        vectors++;
        if ({pulse_o, busy_o, done_o} !== '0) begin
            errs++;
            $display("FAIL reset_outs: got %h want 0",
                     {pulse_o, busy_o, done_o});
        end
        rst_n = 1'b1;
        repeat (2) step("reset_idle");
    endtask

    task automatic test_basic();
        arm(0, 10, 3, 4, 0);
        step("basic");
        repeat (40) step("basic");
        // Restart in the done cycle.
        arm(0, 2, 1, 1, 0);
        repeat (6) step("restart_done");
    endtask

    task automatic test_sync();
        arm(1, 8, 2, 2, 1);
        step("sync");
        repeat (20) step("sync_wait");
        sync_i = 1'b1;
        repeat (19) step("sync_run");
        sync_i = 1'b0;
        repeat (2) step("sync_tail");
    endtask

    task automatic test_continuous();
        arm(2, 5, 5, 0, 0);
        step("cont");
        repeat (14) step("cont");
        stop_i[2] = 1'b1;
        repeat (5) step("cont_stop");
    endtask

    task automatic test_all();
        arm(0, 4, 2, 3, 0);
        arm(1, 6, 3, 2, 0);
        arm(2, 7, 1, 0, 0);
        arm(3, 9, 4, 3, 0);
        step("all");
        repeat (5) step("all");
        arm(3, 3, 1, 1, 0);
        repeat (11) step("all_busy_start");
        arm(0, 3, 1, 5, 0);
        stop_i[0] = 1'b1;
        repeat (13) step("all_start_stop");
        stop_i[2] = 1'b1;
        repeat (16) step("all_tail");
    endtask

    task automatic test_width0();
        arm(1, 5, 0, 3, 1);
        repeat (4) step("width0");
    endtask

    task automatic test_cfg_change();
        arm(3, 6, 2, 3, 0);
        step("cfg");
        repeat (20) begin
            period_i  = {$urandom, $urandom, $urandom, $urandom};
            width_i   = {$urandom, $urandom, $urandom, $urandom};
            count_i   = {$urandom, $urandom, $urandom, $urandom};
            sync_en_i = 4'($urandom);
            step("cfg_change");
        end
        period_i  = '0;
        width_i   = '0;
        count_i   = '0;
        sync_en_i = '0;
    endtask

    task automatic test_reset_mid();
        arm(0, 10, 3, 4, 0);
        arm(2, 5, 5, 0, 0);
        repeat (2) step("rst_mid_pre");
        #2;
        rst_n = 1'b0;
        #1;
        vectors++;
        if ({pulse_o, busy_o, done_o} !== '0) begin
            errs++;
            $display("FAIL reset_async: got %h want 0",
                     {pulse_o, busy_o, done_o});
        end
        clear_plans();
        repeat (2) begin
            @(posedge clk);
            cyc++;
        end
        #1;
        rst_n = 1'b1;
        arm(0, 6, 1, 1, 0);
        repeat (9) step("rst_fresh");
    endtask

    initial begin
        test_reset();
        test_basic();
        test_sync();
        test_continuous();
        test_all();
        test_width0();
        test_cfg_change();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule
